// File: rtl/sd2bin_otf_converter_pkg.sv
// ---------------------------------------------------------------------------
// sd_pkg
// Shared encodings for the signed-digit to binary on-the-fly converter.
//   digit_t     : one radix-2 signed digit packed as {p, n}
//   DIGIT_*     : digit encodings (p=n=1 is also treated as zero)
//   ST_*        : converter state encoding
//   cnt_width() : width of the digit counter for a given word length
// ---------------------------------------------------------------------------
package sd_pkg;

    typedef logic [1:0] digit_t;

    localparam digit_t DIGIT_POS  = 2'b10;
    localparam digit_t DIGIT_ZERO = 2'b00;
    localparam digit_t DIGIT_NEG  = 2'b01;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACC  = 1'b1;

    // Counter must hold the value no_of_digits itself.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sd2bin_otf_converter_if.sv
// ---------------------------------------------------------------------------
// sd2bin_otf_converter_if
// Digit stream in, converted word out.
//   in_valid  : digit presented this cycle
//   in_first  : qualifies in_valid, marks the most significant digit
//   din_p/n   : signed digit, {p,n} = 10 -> +1, 01 -> -1, equal -> 0
//   result    : two's-complement value of the last completed word
//   out_valid : one-cycle pulse when result updates
//   busy      : a word is partially accepted
// Modports: master drives digits (producer), slave is the converter.
// ---------------------------------------------------------------------------
interface sd2bin_otf_converter_if #(
    parameter int no_of_digits = 8
) ();

    logic                    in_valid;
    logic                    in_first;
    logic                    din_p;
    logic                    din_n;
    logic [no_of_digits:0]   result;
    logic                    out_valid;
    logic                    busy;

    modport master (
        output in_valid, in_first, din_p, din_n,
        input  result, out_valid, busy
    );

    modport slave (
        input  in_valid, in_first, din_p, din_n,
        output result, out_valid, busy
    );

endinterface

// File: rtl/sd2bin_otf_converter_digit_update.sv
// ---------------------------------------------------------------------------
// otf_digit_update
// Combinational on-the-fly conversion step. Appends one signed digit to the
// pair (Q, QM = Q-1) using only selection and concatenation, so no carry
// chain exists regardless of word length.
//   q_i, qm_i         : current Q and QM
//   din_p_i, din_n_i  : digit to append
//   q_o, qm_o         : updated Q and QM
// ---------------------------------------------------------------------------
module otf_digit_update
    import sd_pkg::*;
#(
    parameter int W = 9
) (
    input  logic signed [W-1:0] q_i,
    input  logic signed [W-1:0] qm_i,
    input  logic                din_p_i,
    input  logic                din_n_i,
    output logic signed [W-1:0] q_o,
    output logic signed [W-1:0] qm_o
);

    // The MSBs are shifted out; the value always fits in W bits.
    logic unused_msb;
    assign unused_msb = q_i[W-1] ^ qm_i[W-1];

    always_comb begin
        // Zero digit (either encoding): Q = 2Q, QM = 2QM + 1
        q_o  = {q_i[W-2:0], 1'b0};
        qm_o = {qm_i[W-2:0], 1'b1};
        case (digit_t'({din_p_i, din_n_i}))
            DIGIT_POS: begin
                q_o  = {q_i[W-2:0], 1'b1};
                qm_o = {q_i[W-2:0], 1'b0};
            end
            DIGIT_NEG: begin
                // 2Q - 1 == 2(Q-1) + 1, so the new Q comes from QM
                q_o  = {qm_i[W-2:0], 1'b1};
                qm_o = {qm_i[W-2:0], 1'b0};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/sd2bin_otf_converter.sv
// ---------------------------------------------------------------------------
// sd2bin_otf_converter
// Converts an MSD-first stream of radix-2 signed digits into a two's-
// complement integer of no_of_digits+1 bits by on-the-fly conversion.
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : sd2bin_otf_converter_if slave (digits in, result/out_valid/busy out)
// A digit with in_first always starts a fresh word, abandoning any partial
// one. The result registers on the edge that accepts the last digit and
// out_valid pulses in the following cycle, during which the next word's
// first digit may already be presented.
// ---------------------------------------------------------------------------
module sd2bin_otf_converter
    import sd_pkg::*;
#(
    parameter int no_of_digits = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sd2bin_otf_converter_if.slave bus
);

    localparam int W     = no_of_digits + 1;
    localparam int CNT_W = cnt_width(no_of_digits);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(no_of_digits);

    logic [0:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic signed [W-1:0] q_q, q_d;
    logic signed [W-1:0] qm_q, qm_d;
    logic signed [W-1:0] result_q, result_d;
    logic                out_valid_q, out_valid_d;

    logic                start;
    logic                accept;
    logic signed [W-1:0] q_src, qm_src;
    logic signed [W-1:0] q_upd, qm_upd;

    assign start  = bus.in_valid & bus.in_first;
    assign accept = start | (bus.in_valid & (state_q == ST_ACC));

    // A new word starts from Q = 0, QM = -1 regardless of held state.
    assign q_src  = start ? '0 : q_q;
    assign qm_src = start ? '1 : qm_q;

    otf_digit_update #(
        .W (W)
    ) u_digit_update (
        .q_i     (q_src),
        .qm_i    (qm_src),
        .din_p_i (bus.din_p),
        .din_n_i (bus.din_n),
        .q_o     (q_upd),
        .qm_o    (qm_upd)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        qm_d        = qm_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        if (accept) begin
            q_d   = q_upd;
            qm_d  = qm_upd;
            cnt_d = start ? CNT_ONE : cnt_q + CNT_ONE;
            if (cnt_d == CNT_LAST) begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                result_d    = q_upd;
                out_valid_d = 1'b1;
            end else begin
                state_d = ST_ACC;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            q_q         <= '0;
            qm_q        <= '1;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            qm_q        <= qm_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q == ST_ACC);

endmodule

// File: tb/tb_sd2bin_otf_converter.sv
// ---------------------------------------------------------------------------
// tb_sd2bin_otf_converter
// Directed bench for sd2bin_otf_converter with no_of_digits = 8. Each word's
// expected value and completion cycle are queued when its last digit is
// driven; a negedge monitor pops and compares whenever out_valid is seen and
// flags pulses that arrive unexpectedly or not at all.
// ---------------------------------------------------------------------------
module tb_sd2bin_otf_converter;

    localparam int N = 8;

    typedef int word_t [N];
    typedef struct {
        logic [N:0] val;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t sb[$];
    exp_t e;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sd2bin_otf_converter_if #(.no_of_digits(N)) bus_if ();

    sd2bin_otf_converter #(
        .no_of_digits (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int dval(input int d);
        return (d == 1) ? 1 : ((d == -1) ? -1 : 0);
    endfunction

    // Reference value: plain weighted sum of the digits.
    function automatic logic [N:0] word_value(input word_t w);
        int v;
        v = 0;
        for (int k = 0; k < N; k++) v += dval(w[k]) * (1 << (N - 1 - k));
        return v[N:0];
    endfunction

    // Digit codes: 1 -> +1, -1 -> -1, 0 -> zero (p=n=0), 2 -> zero (p=n=1).
    task automatic drive(input int d, input bit first);
        bus_if.in_valid = 1'b1;
        bus_if.in_first = first;
        bus_if.din_p    = (d == 1) || (d == 2);
        bus_if.din_n    = (d == -1) || (d == 2);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        bus_if.in_first = 1'b0;
        bus_if.din_p    = 1'b0;
        bus_if.din_n    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input word_t w, input int gap);
        exp_t x;
        for (int k = 0; k < N; k++) begin
            if (k == N - 1) begin
                x.val = word_value(w);
                x.cyc = cyc + 1;
                sb.push_back(x);
            end
            drive(w[k], k == 0);
            if (k < N - 1) idle(gap);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.out_valid) begin
                check("out_valid_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("result", 32'(bus_if.result), 32'(e.val));
                    check("latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
                e = sb.pop_front();
                check("out_valid_missing_at", 32'(cyc), 32'(e.cyc - 1));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1, "timeout");
    end

    initial begin
        word_t wa, wb, wc, wd, we, wf;
        wa = '{1, 0, 0, 0, 0, 0, 0, 0};
        wb = '{-1, -1, -1, -1, -1, -1, -1, -1};
        wc = '{0, 0, 0, 0, 0, 0, 0, -1};
        wd = '{1, -1, 0, 0, 0, 0, 0, 0};
        we = '{1, 0, -1, 1, 2, 0, -1, 1};
        for (int k = 0; k < N; k++) wf[k] = int'($urandom_range(0, 3)) - 1;

        bus_if.in_valid = 1'b0;
        bus_if.in_first = 1'b0;
        bus_if.din_p    = 1'b0;
        bus_if.din_n    = 1'b0;

        // Reset state
        idle(2);
        check("reset_busy", 32'(bus_if.busy), 32'd0);
        check("reset_result", 32'(bus_if.result), 32'd0);
        check("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
        rst = 1'b0;
        idle(1);

        // Digits without in_first are ignored in IDLE
        drive(1, 1'b0);
        drive(-1, 1'b0);
        check("idle_ignore_busy", 32'(bus_if.busy), 32'd0);

        // +1 then zeros -> 128, followed back-to-back by -255 and -1
        send_word(wa, 0);
        check("busy_after_word", 32'(bus_if.busy), 32'd0);
        send_word(wb, 0);
        send_word(wc, 0);
        idle(3);
        check("result_hold", 32'(bus_if.result), 32'h1FF);

        // +1,-1,0... with 3-cycle gaps -> 64
        send_word(wd, 3);

        // Partial word abandoned by a new in_first
        idle(2);
        for (int k = 0; k < 4; k++) drive(1, k == 0);
        check("partial_busy", 32'(bus_if.busy), 32'd1);
        send_word(wa, 0);

        // Reset mid-word
        idle(2);
        for (int k = 0; k < 5; k++) drive(-1, k == 0);
        check("midword_busy", 32'(bus_if.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_result", 32'(bus_if.result), 32'd0);
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 1'b0);
        check("post_rst_needs_first", 32'(bus_if.busy), 32'd0);

        // Two back-to-back words after reset
        send_word(we, 0);
        send_word(wf, 0);

        idle(4);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("final_result", 32'(bus_if.result), 32'(word_value(wf)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
